kf6845_light_pen: RTL and testbench
===================================

Name: kf6845_light_pen

Overview:
- Light-pen capture block for the KF6845 CRTC. It is the inverse path of cursor control: the cursor block compares a CPU-written address against MA and drives a pulse out. This block takes an asynchronous strobe in, latches the MA value current at that time into a register, and exposes that register to the CPU read path together with a status flag.
- It sits beside the cursor block on the internal data bus and observes the same MA bus from the address generator.

Parameters:
- SYNC_STAGES, 2: number of flip-flops in the LPSTB synchronizer. Legal range is 2 to 4.
- MA_DELAY, 2: depth of the MA history pipeline, in character clocks. It compensates for pen and display latency. Legal range is 0 to 7. A value of 0 means the live MA is used.
- LOCK_FIRST, 1: when 1, the first capture is held until the CPU reads it. When 0, each new strobe overwrites the previous capture.

Ports:
- clock, input, 1: system clock. All state is on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- video_clock_enable, input, 1: character-clock enable. Advances the MA history pipeline.
- LPSTB, input, 1: light pen strobe. Asynchronous and active-high.
- MA, input, 14: current refresh memory address.
- read_light_pen_h_register, input, 1: CPU read select for R16.
- read_light_pen_l_register, input, 1: CPU read select for R17.
- internal_data_bus_out, output, 8: read data.
- light_pen_strobe_flag, output, 1: a capture is held and not yet read.

Behaviour:
- Reset (reset_n=0, asynchronous) clears:
  - all synchronizer flops, the edge-detect flop and every pipeline stage to 0;
  - light_pen_address to 14'h0;
  - light_pen_strobe_flag to 0.
  During reset internal_data_bus_out reads 8'hFF, since no read select is active.
- Synchronizer and edge detect:
  - LPSTB passes through a chain of SYNC_STAGES flops, giving sync_out.
  - A prev flop registers sync_out.
  - edge = sync_out & ~prev.
  - Only rising edges count; a held-high LPSTB produces exactly one edge.
- MA history pipeline:
  - Each stage shifts only on clock edges where video_clock_enable=1. Stage 0 takes MA, and stage i takes stage i-1.
  - tap = stage MA_DELAY-1. When MA_DELAY=0, tap = MA directly.
  - The pipeline holds its value while video_clock_enable=0.
- Capture, on a clock edge where edge=1:
  - If flag=0: light_pen_address takes tap and flag becomes 1.
  - If flag=1 and LOCK_FIRST=1: the edge is ignored and address and flag are unchanged.
  - If flag=1 and LOCK_FIRST=0: light_pen_address takes tap and flag stays 1.
- Latency (SYNC_STAGES=2), counting from the first clock edge that samples LPSTB high:
  - sync_out is 1 after edge +1;
  - the capture happens at edge +2;
  - flag is 1 from edge +2 onward.
  In general, the capture happens at edge +SYNC_STAGES.
- Read mux (combinational):
  - read_light_pen_h_register=1 gives {2'b00, light_pen_address[13:8]}.
  - Otherwise, read_light_pen_l_register=1 gives light_pen_address[7:0].
  - Otherwise 8'hFF.
  - H has priority when both selects are asserted.
- Flag clear:
  - A registered copy of read_light_pen_l_register is kept. The flag clears on the clock edge where the registered copy is 1 and the live select is 0, i.e. one cycle after the L read ends.
  - A multi-cycle L read clears the flag once. H reads never clear it.
  - Capture and clear on the same edge: the capture wins. The flag stays 1 and the address is updated, overriding LOCK_FIRST because the held value was just consumed.
- Reset mid-operation:
  - An in-flight strobe is lost.
  - If LPSTB is still high when reset_n releases, the zeroed synchronizer sees a rising edge, so one capture occurs SYNC_STAGES+1 edges after release.
- Address width: the 14-bit capture is taken as-is, with no arithmetic. The delay compensation is purely the pipeline.

Test Plan:
- Reset, no strobe:
  - reset_n low then high → flag=0 and bus=8'hFF.
  - H read → 8'h00; L read → 8'h00.
- Basic capture, MA_DELAY=0:
  - Hold MA=14'h1234 and pulse LPSTB for 5 clocks → flag rises 2 edges after the first high sample.
  - H read → 8'h12; L read → 8'h34.
  - Flag=0 one cycle after the L read ends.
- Delay compensation, MA_DELAY=2:
  - Drive MA incrementing 14'h0100, 0101, … with video_clock_enable every 4th clock.
  - Strobe when the live MA is 14'h0105 → captured value is 14'h0103 (two character clocks earlier; exact tap checked against the model).
- LOCK_FIRST=1:
  - Strobe at MA=14'h0200, then strobe at MA=14'h0300 without a read → L read returns 8'h00 and H read returns 8'h02.
  - With LOCK_FIRST=0, the same sequence returns 14'h0300.
- Simultaneous events:
  - Schedule a capture at MA=14'h3FFF on the same edge as the L-read clear → flag remains 1 and the address is 14'h3FFF.
  - H read → 8'h3F.
- Reset mid-strobe:
  - Assert reset_n=0 while LPSTB is high, then release with LPSTB still high → exactly one capture, SYNC_STAGES+1 edges after release.
  - No further captures until LPSTB goes low and high again.

Source files
------------

// File: rtl/kf6845_light_pen.sv
// KF6845 light-pen capture: synchronizes LPSTB, latches a delayed MA on its
// rising edge and presents the captured address on the R16/R17 read path.
module kf6845_light_pen #(
    parameter int SYNC_STAGES = 2,
    parameter int MA_DELAY    = 2,
    parameter int LOCK_FIRST  = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        video_clock_enable,
    input  logic        LPSTB,
    input  logic [13:0] MA,
    input  logic        read_light_pen_h_register,
    input  logic        read_light_pen_l_register,
    output logic [7:0]  internal_data_bus_out,
    output logic        light_pen_strobe_flag
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q;
    logic                   rd_l_q;
    logic [13:0]            addr_q, addr_d;
    logic                   flag_q, flag_d;
    logic [13:0]            tap;
    logic                   lp_edge;
    logic                   rd_clear;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], LPSTB};
    assign lp_edge  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign rd_clear = rd_l_q & ~read_light_pen_l_register;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rd_l_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
            rd_l_q <= read_light_pen_l_register;
        end
    end

    // MA history advances on character clocks only, so the tap is MA_DELAY characters old.
    generate
        if (MA_DELAY == 0) begin : g_live
            assign tap = MA;
        end else begin : g_pipe
            logic [13:0] pipe_q [MA_DELAY];

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < MA_DELAY; i++) pipe_q[i] <= '0;
                end else if (video_clock_enable) begin
                    pipe_q[0] <= MA;
                    for (int i = 1; i < MA_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign tap = pipe_q[MA_DELAY-1];
        end
    endgenerate

    // A clear on the capture edge means the held value was consumed, so the new strobe may overwrite it.
    always_comb begin
        addr_d = addr_q;
        flag_d = flag_q;
        if (lp_edge) begin
            if (!flag_q || (LOCK_FIRST == 0) || rd_clear) addr_d = tap;
            flag_d = 1'b1;
        end else if (rd_clear) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= 14'h0;
            flag_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            flag_q <= flag_d;
        end
    end

    always_comb begin
        internal_data_bus_out = 8'hFF;
        if (read_light_pen_h_register)      internal_data_bus_out = {2'b00, addr_q[13:8]};
        else if (read_light_pen_l_register) internal_data_bus_out = addr_q[7:0];
    end

    assign light_pen_strobe_flag = flag_q;

endmodule

// File: tb/tb_kf6845_light_pen.sv
// Bench for kf6845_light_pen: three instances (live MA / delayed+locked /
// delayed+overwrite) checked against a history-based reference model.
module tb_kf6845_light_pen;

    localparam int SYNC = 2;

    logic        clock;
    logic        reset_n;
    logic        vce;
    logic        lpstb;
    logic [13:0] ma;
    logic        rd_h;
    logic        rd_l;
    logic [7:0]  bus  [3];
    logic        flag [3];

    int errors = 0;
    int checks = 0;

    kf6845_light_pen #(.SYNC_STAGES(SYNC), .MA_DELAY(0), .LOCK_FIRST(1)) u_d0 (
        .clock(clock), .reset_n(reset_n), .video_clock_enable(vce), .LPSTB(lpstb), .MA(ma),
        .read_light_pen_h_register(rd_h), .read_light_pen_l_register(rd_l),
        .internal_data_bus_out(bus[0]), .light_pen_strobe_flag(flag[0]));

    kf6845_light_pen #(.SYNC_STAGES(SYNC), .MA_DELAY(2), .LOCK_FIRST(1)) u_d1 (
        .clock(clock), .reset_n(reset_n), .video_clock_enable(vce), .LPSTB(lpstb), .MA(ma),
        .read_light_pen_h_register(rd_h), .read_light_pen_l_register(rd_l),
        .internal_data_bus_out(bus[1]), .light_pen_strobe_flag(flag[1]));

    kf6845_light_pen #(.SYNC_STAGES(SYNC), .MA_DELAY(2), .LOCK_FIRST(0)) u_d2 (
        .clock(clock), .reset_n(reset_n), .video_clock_enable(vce), .LPSTB(lpstb), .MA(ma),
        .read_light_pen_h_register(rd_h), .read_light_pen_l_register(rd_l),
        .internal_data_bus_out(bus[2]), .light_pen_strobe_flag(flag[2]));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int md(int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic int lf(int i);
        return (i == 2) ? 0 : 1;
    endfunction

    function automatic logic [7:0] model_bus(logic [13:0] a, logic h, logic l);
        if (h) return {2'b00, a[13:8]};
        if (l) return a[7:0];
        return 8'hFF;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: strobe samples and character-clock MA values kept as plain histories.
    logic [SYNC:0] samp;
    logic [13:0]   mah [8];
    logic          m_rdl;
    logic          m_flag [3];
    logic [13:0]   m_addr [3];

    always @(posedge clock or negedge reset_n) begin : model
        logic        rise;
        logic        consumed;
        logic [13:0] t;
        if (!reset_n) begin
            samp  <= '0;
            m_rdl <= 1'b0;
            for (int k = 0; k < 8; k++) mah[k] <= '0;
            for (int i = 0; i < 3; i++) begin
                m_flag[i] <= 1'b0;
                m_addr[i] <= '0;
            end
        end else begin
            rise     = samp[SYNC-1] & ~samp[SYNC];
            consumed = m_rdl & ~rd_l;
            for (int i = 0; i < 3; i++) begin
                if (md(i) == 0) t = ma;
                else            t = mah[md(i)-1];
                if (rise) begin
                    if (!m_flag[i] || lf(i) == 0 || consumed) m_addr[i] <= t;
                    m_flag[i] <= 1'b1;
                end else if (consumed) begin
                    m_flag[i] <= 1'b0;
                end
            end
            samp  <= {samp[SYNC-1:0], lpstb};
            m_rdl <= rd_l;
            if (vce) begin
                mah[0] <= ma;
                for (int k = 1; k < 8; k++) mah[k] <= mah[k-1];
            end
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("model_flag%0d", i), {31'd0, flag[i]}, {31'd0, m_flag[i]});
            check($sformatf("model_bus%0d", i), {24'd0, bus[i]}, {24'd0, model_bus(m_addr[i], rd_h, rd_l)});
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        lpstb = 1'b0; vce = 1'b0; rd_h = 1'b0; rd_l = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic fill_ma(logic [13:0] v);
        ma = v; vce = 1'b1;
        tick(3);
        vce = 1'b0;
    endtask

    task automatic pulse();
        lpstb = 1'b1;
        tick(3);
        lpstb = 1'b0;
        tick(3);
    endtask

    task automatic check_all_bus(string name, logic [7:0] e0, logic [7:0] e1, logic [7:0] e2);
        #1;
        check({name, "_0"}, {24'd0, bus[0]}, {24'd0, e0});
        check({name, "_1"}, {24'd0, bus[1]}, {24'd0, e1});
        check({name, "_2"}, {24'd0, bus[2]}, {24'd0, e2});
    endtask

    task automatic check_all_flag(string name, logic e);
        check({name, "_0"}, {31'd0, flag[0]}, {31'd0, e});
        check({name, "_1"}, {31'd0, flag[1]}, {31'd0, e});
        check({name, "_2"}, {31'd0, flag[2]}, {31'd0, e});
    endtask

    typedef struct {
        logic       h;
        logic       l;
        logic [7:0] exp_bus;
        logic       exp_flag;
    } rd_vec_t;

    rd_vec_t rd_tab [5];

    initial begin
        rd_tab[0] = '{h: 1'b0, l: 1'b0, exp_bus: 8'hFF, exp_flag: 1'b1};
        rd_tab[1] = '{h: 1'b1, l: 1'b0, exp_bus: 8'h12, exp_flag: 1'b1};
        rd_tab[2] = '{h: 1'b1, l: 1'b1, exp_bus: 8'h12, exp_flag: 1'b1};
        rd_tab[3] = '{h: 1'b0, l: 1'b1, exp_bus: 8'h34, exp_flag: 1'b1};
        rd_tab[4] = '{h: 1'b0, l: 1'b0, exp_bus: 8'hFF, exp_flag: 1'b1};

        reset_n = 1'b0;
        lpstb = 1'b0; vce = 1'b0; rd_h = 1'b0; rd_l = 1'b0; ma = 14'h0;

        // Reset state and idle reads
        tick(2);
        check_all_flag("rst_flag", 1'b0);
        check_all_bus("rst_bus", 8'hFF, 8'hFF, 8'hFF);
        reset_n = 1'b1;
        tick(1);
        rd_h = 1'b1;
        check_all_bus("idle_h", 8'h00, 8'h00, 8'h00);
        rd_h = 1'b0; rd_l = 1'b1;
        check_all_bus("idle_l", 8'h00, 8'h00, 8'h00);
        rd_l = 1'b0;
        tick(2);

        // Basic capture latency and read table
        fill_ma(14'h1234);
        lpstb = 1'b1;
        tick(1); check("lat_e0", {31'd0, flag[0]}, 32'd0);
        tick(1); check("lat_e1", {31'd0, flag[0]}, 32'd0);
        tick(1); check("lat_e2", {31'd0, flag[0]}, 32'd1);
        tick(2);
        lpstb = 1'b0;
        tick(1);
        for (int v = 0; v < 5; v++) begin
            rd_h = rd_tab[v].h;
            rd_l = rd_tab[v].l;
            #1;
            check($sformatf("rdtab_bus%0d", v), {24'd0, bus[0]}, {24'd0, rd_tab[v].exp_bus});
            check($sformatf("rdtab_flag%0d", v), {31'd0, flag[0]}, {31'd0, rd_tab[v].exp_flag});
            tick(1);
        end
        check_all_flag("clr_after_l", 1'b0);

        // Delay compensation: strobe while live MA is 0x0105
        do_reset();
        for (int p = 0; p < 7; p++) begin
            ma = 14'h0100 + 14'(p);
            for (int c = 0; c < 4; c++) begin
                vce = (c == 3);
                if (p == 5 && c == 0) lpstb = 1'b1;
                if (p == 6 && c == 0) lpstb = 1'b0;
                tick(1);
            end
        end
        vce = 1'b0;
        rd_h = 1'b1;
        check_all_bus("dly_h", 8'h01, 8'h01, 8'h01);
        rd_h = 1'b0; rd_l = 1'b1;
        check_all_bus("dly_l", 8'h05, 8'h03, 8'h03);
        rd_l = 1'b0;
        tick(2);

        // Lock-first versus overwrite
        do_reset();
        fill_ma(14'h0200);
        pulse();
        fill_ma(14'h0300);
        pulse();
        check_all_flag("lock_flag", 1'b1);
        rd_h = 1'b1;
        check_all_bus("lock_h", 8'h02, 8'h02, 8'h03);
        rd_h = 1'b0; rd_l = 1'b1;
        check_all_bus("lock_l", 8'h00, 8'h00, 8'h00);
        rd_l = 1'b0;
        tick(2);

        // Capture on the same edge as the L-read clear
        do_reset();
        fill_ma(14'h0000);
        pulse();
        fill_ma(14'h3FFF);
        lpstb = 1'b1;
        tick(1);
        rd_l = 1'b1;
        tick(1);
        rd_l = 1'b0;
        tick(1);
        lpstb = 1'b0;
        check_all_flag("simul_flag", 1'b1);
        rd_h = 1'b1;
        check_all_bus("simul_h", 8'h3F, 8'h3F, 8'h3F);
        rd_h = 1'b0; rd_l = 1'b1;
        check_all_bus("simul_l", 8'hFF, 8'hFF, 8'hFF);
        tick(1);
        rd_l = 1'b0;
        tick(1);
        check_all_flag("simul_clr", 1'b0);

        // Reset while the strobe is high
        do_reset();
        ma = 14'h0ABC; vce = 1'b1;
        tick(3);
        lpstb = 1'b1;
        tick(1);
        reset_n = 1'b0;
        #1;
        check_all_flag("midrst_flag", 1'b0);
        tick(2);
        reset_n = 1'b1;
        tick(1); check_all_flag("rel_e1", 1'b0);
        tick(1); check_all_flag("rel_e2", 1'b0);
        tick(1); check_all_flag("rel_e3", 1'b1);
        rd_l = 1'b1;
        check_all_bus("rel_l", 8'hBC, 8'hBC, 8'hBC);
        tick(1);
        rd_l = 1'b0;
        tick(1);
        for (int k = 0; k < 6; k++) begin
            check_all_flag($sformatf("held_%0d", k), 1'b0);
            tick(1);
        end
        lpstb = 1'b0;
        tick(3);
        lpstb = 1'b1;
        tick(3);
        check_all_flag("restrobe", 1'b1);
        lpstb = 1'b0;
        vce = 1'b0;

        // Randomized traffic, checked every cycle against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) lpstb = ~lpstb;
            ma   = 14'($urandom);
            vce  = ($urandom_range(0, 2) == 0);
            rd_h = ($urandom_range(0, 9) == 0);
            rd_l = ($urandom_range(0, 6) == 0);
            tick(1);
        end
        rd_h = 1'b0; rd_l = 1'b0; lpstb = 1'b0;
        tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
